// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS control unit and its datapath.
// The master side is the control FSM; the slave side is the datapath/IR.
interface mips_mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ir_wr;
    logic       dm_wr;
    logic       rf_wr;
    logic [1:0] rf_a3_sel;
    logic [1:0] rf_wd_sel;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output pc_wr, pc_src, ir_wr, dm_wr, rf_wr, rf_a3_sel, rf_wd_sel,
               alu_a_sel, alu_b_sel, ext_op, alu_op, state, instr_done, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, pc_src, ir_wr, dm_wr, rf_wr, rf_a3_sel, rf_wd_sel,
               alu_a_sel, alu_b_sel, ext_op, alu_op, state, instr_done, illegal
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Moore-style multi-cycle MIPS control unit: sequences FETCH/DCD/EXE/MEM/WB
// and decodes datapath enables, mux selects and ALU op from the state register.
module mips_mc_ctrl #(
    parameter int ZERO_BRANCH = 1
) (
    input logic           clk,
    input logic           rst,
    mips_mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DCD     = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_WB_R    = 4'd8,
        S_WB_I    = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
        case (f)
            6'b100011: funct_alu_op = ALU_SUB;
            6'b100100: funct_alu_op = ALU_AND;
            6'b100101: funct_alu_op = ALU_OR;
            6'b101010: funct_alu_op = ALU_SLT;
            default:   funct_alu_op = ALU_ADD;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic       pc_wr_s, ir_wr_s, dm_wr_s, rf_wr_s, done_s, illegal_s;
    logic [1:0] pc_src_s, rf_a3_sel_s, rf_wd_sel_s, alu_b_sel_s, ext_op_s;
    logic       alu_a_sel_s;
    logic [2:0] alu_op_s;
    logic       br_taken_s;

    // Only the zero-taken branch flavour is defined; other settings never branch.
    assign br_taken_s = (ZERO_BRANCH != 0) ? bus.zero : 1'b0;

    // Next-state and per-state datapath control decode.
    always_comb begin
        state_d     = state_q;
        pc_wr_s     = 1'b0;
        pc_src_s    = 2'd0;
        ir_wr_s     = 1'b0;
        dm_wr_s     = 1'b0;
        rf_wr_s     = 1'b0;
        rf_a3_sel_s = 2'd0;
        rf_wd_sel_s = 2'd0;
        alu_a_sel_s = 1'b0;
        alu_b_sel_s = 2'd0;
        ext_op_s    = 2'd0;
        alu_op_s    = ALU_ADD;
        done_s      = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_wr_s     = 1'b1;
                pc_wr_s     = 1'b1;
                alu_b_sel_s = 2'd1;
                state_d     = S_DCD;
            end
            S_DCD: begin
                alu_b_sel_s = 2'd3;
                ext_op_s    = 2'd1;
                case (bus.op)
                    OP_RTYPE: begin
                        if (funct_ok(bus.funct)) begin
                            state_d = S_EXE_R;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_s = 1'b1;
                        end
                    end
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXE_I;
                    OP_LW, OP_SW:            state_d = S_MEM_ADR;
                    OP_BEQ:                  state_d = S_BRANCH;
                    OP_J, OP_JAL:            state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_EXE_R: begin
                alu_a_sel_s = 1'b1;
                alu_op_s    = funct_alu_op(bus.funct);
                state_d     = S_WB_R;
            end
            S_WB_R: begin
                rf_wr_s     = 1'b1;
                rf_a3_sel_s = 2'd1;
                done_s      = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXE_I: begin
                alu_a_sel_s = 1'b1;
                alu_b_sel_s = 2'd2;
                state_d     = S_WB_I;
                // lui relies on rs=$0 so that A + (imm<<16) is the result.
                case (bus.op)
                    OP_ORI: begin
                        ext_op_s = 2'd0;
                        alu_op_s = ALU_OR;
                    end
                    OP_LUI: begin
                        ext_op_s = 2'd2;
                        alu_op_s = ALU_ADD;
                    end
                    default: begin
                        ext_op_s = 2'd1;
                        alu_op_s = ALU_ADD;
                    end
                endcase
            end
            S_WB_I: begin
                rf_wr_s = 1'b1;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_ADR: begin
                alu_a_sel_s = 1'b1;
                alu_b_sel_s = 2'd2;
                ext_op_s    = 2'd1;
                if (bus.op == OP_LW) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: state_d = S_MEM_WB;
            S_MEM_WB: begin
                rf_wr_s     = 1'b1;
                rf_wd_sel_s = 2'd1;
                done_s      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                dm_wr_s = 1'b1;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_sel_s = 1'b1;
                alu_op_s    = ALU_SUB;
                pc_src_s    = 2'd1;
                pc_wr_s     = br_taken_s;
                done_s      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_wr_s  = 1'b1;
                pc_src_s = 2'd2;
                done_s   = 1'b1;
                state_d  = S_FETCH;
                // PC already holds PC+4 here, so jal links it straight into $31.
                if (bus.op == OP_JAL) begin
                    rf_wr_s     = 1'b1;
                    rf_a3_sel_s = 2'd2;
                    rf_wd_sel_s = 2'd2;
                end else begin
                    rf_wr_s = 1'b0;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Side effects are suppressed during the reset cycle itself.
    assign bus.pc_wr      = pc_wr_s   & ~rst;
    assign bus.ir_wr      = ir_wr_s   & ~rst;
    assign bus.dm_wr      = dm_wr_s   & ~rst;
    assign bus.rf_wr      = rf_wr_s   & ~rst;
    assign bus.instr_done = done_s    & ~rst;
    assign bus.illegal    = illegal_s & ~rst;
    assign bus.pc_src     = pc_src_s;
    assign bus.rf_a3_sel  = rf_a3_sel_s;
    assign bus.rf_wd_sel  = rf_wd_sel_s;
    assign bus.alu_a_sel  = alu_a_sel_s;
    assign bus.alu_b_sel  = alu_b_sel_s;
    assign bus.ext_op     = ext_op_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through its
// state sequence and compares outputs with hand-computed values.
module tb_mips_mc_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mips_mc_ctrl_if bus ();

    mips_mc_ctrl #(.ZERO_BRANCH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.op = 6'b000100;
        bus.funct = 6'b000000;
        bus.zero = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (bus.state !== 4'd10) begin
            errors++;
            $display("FAIL reset_pre_state: got %0d want 10", bus.state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pc_wr !== 1'b0 || bus.instr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_branch_gate: pc_wr=%b done=%b want 0 0", bus.pc_wr, bus.instr_done);
        end
        tick();
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.ir_wr !== 1'b0 || bus.pc_wr !== 1'b0 ||
            bus.rf_wr !== 1'b0 || bus.dm_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: state=%0d ir_wr=%b pc_wr=%b rf_wr=%b dm_wr=%b want 0 0 0 0 0",
                     bus.state, bus.ir_wr, bus.pc_wr, bus.rf_wr, bus.dm_wr);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.ir_wr !== 1'b1 || bus.pc_wr !== 1'b1 ||
            bus.alu_b_sel !== 2'd1 || bus.pc_src !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_fetch: state=%0d ir_wr=%b pc_wr=%b b_sel=%0d want 0 1 1 1",
                     bus.state, bus.ir_wr, bus.pc_wr, bus.alu_b_sel);
        end
    endtask

    // Entered in a FETCH cycle; leaves the DUT in the following FETCH cycle.
    task automatic test_addu();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd0};
        int done_cnt = 0;
        bus.op = 6'b000000;
        bus.funct = 6'b100001;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.state !== exp_st[i]) begin
                errors++;
                $display("FAIL addu_state[%0d]: got %0d want %0d", i, bus.state, exp_st[i]);
            end
            if (i == 1) begin
                checks++;
                if (bus.alu_b_sel !== 2'd3 || bus.ext_op !== 2'd1 || bus.alu_a_sel !== 1'b0) begin
                    errors++;
                    $display("FAIL dcd_outputs: b_sel=%0d ext=%0d a_sel=%b want 3 1 0",
                             bus.alu_b_sel, bus.ext_op, bus.alu_a_sel);
                end
            end
            if (i == 3) begin
                checks++;
                if (bus.rf_wr !== 1'b1 || bus.rf_a3_sel !== 2'd1 || bus.rf_wd_sel !== 2'd0) begin
                    errors++;
                    $display("FAIL addu_wb: rf_wr=%b a3=%0d wd=%0d want 1 1 0",
                             bus.rf_wr, bus.rf_a3_sel, bus.rf_wd_sel);
                end
            end
            if (i < 4 && bus.instr_done === 1'b1) done_cnt++;
            if (i < 4) tick();
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL addu_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_rtype_aluops();
        logic [5:0] fn [5] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ao [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 5; i++) begin
            bus.op = 6'b000000;
            bus.funct = fn[i];
            tick();
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd2 || bus.alu_op !== ao[i] || bus.alu_a_sel !== 1'b1 || bus.alu_b_sel !== 2'd0) begin
                errors++;
                $display("FAIL rtype_exe[%0d]: state=%0d alu_op=%0d a=%b b=%0d want 2 %0d 1 0",
                         i, bus.state, bus.alu_op, bus.alu_a_sel, bus.alu_b_sel, ao[i]);
            end
            tick();
            tick();
        end
    endtask

    task automatic test_itype();
        logic [5:0] opc [3] = '{6'b001000, 6'b001101, 6'b001111};
        logic [1:0] ext [3] = '{2'd1, 2'd0, 2'd2};
        logic [2:0] ao  [3] = '{3'd0, 3'd3, 3'd0};
        for (int i = 0; i < 3; i++) begin
            bus.op = opc[i];
            tick();
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd3 || bus.ext_op !== ext[i] || bus.alu_op !== ao[i] ||
                bus.alu_a_sel !== 1'b1 || bus.alu_b_sel !== 2'd2) begin
                errors++;
                $display("FAIL itype_exe[%0d]: state=%0d ext=%0d alu_op=%0d want 3 %0d %0d",
                         i, bus.state, bus.ext_op, bus.alu_op, ext[i], ao[i]);
            end
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd9 || bus.rf_wr !== 1'b1 || bus.rf_a3_sel !== 2'd0 || bus.instr_done !== 1'b1) begin
                errors++;
                $display("FAIL itype_wb[%0d]: state=%0d rf_wr=%b a3=%0d done=%b want 9 1 0 1",
                         i, bus.state, bus.rf_wr, bus.rf_a3_sel, bus.instr_done);
            end
            tick();
        end
    endtask

    task automatic test_lw_sw();
        logic [3:0] lw_st [5] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6};
        logic [3:0] sw_st [4] = '{4'd0, 4'd1, 4'd4, 4'd7};
        bus.op = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.state !== lw_st[i] || bus.dm_wr !== 1'b0 || bus.rf_wr !== (i == 4)) begin
                errors++;
                $display("FAIL lw_step[%0d]: state=%0d dm_wr=%b rf_wr=%b want %0d 0 %b",
                         i, bus.state, bus.dm_wr, bus.rf_wr, lw_st[i], (i == 4));
            end
            if (i == 4) begin
                checks++;
                if (bus.rf_wd_sel !== 2'd1 || bus.rf_a3_sel !== 2'd0 || bus.instr_done !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_wb: wd=%0d a3=%0d done=%b want 1 0 1",
                             bus.rf_wd_sel, bus.rf_a3_sel, bus.instr_done);
                end
            end
            tick();
        end
        bus.op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.state !== sw_st[i] || bus.dm_wr !== (i == 3) || bus.rf_wr !== 1'b0) begin
                errors++;
                $display("FAIL sw_step[%0d]: state=%0d dm_wr=%b rf_wr=%b want %0d %b 0",
                         i, bus.state, bus.dm_wr, bus.rf_wr, sw_st[i], (i == 3));
            end
            tick();
        end
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++;
            $display("FAIL sw_return: state=%0d want 0", bus.state);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            bus.op = 6'b000100;
            bus.zero = z[0];
            tick();
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd10 || bus.pc_wr !== z[0] || bus.pc_src !== 2'd1 ||
                bus.alu_op !== 3'd1 || bus.instr_done !== 1'b1) begin
                errors++;
                $display("FAIL beq_z%0d: state=%0d pc_wr=%b src=%0d alu=%0d done=%b want 10 %0d 1 1 1",
                         z, bus.state, bus.pc_wr, bus.pc_src, bus.alu_op, bus.instr_done, z);
            end
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd0) begin
                errors++;
                $display("FAIL beq_len_z%0d: state=%0d want 0", z, bus.state);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jump();
        for (int k = 0; k < 2; k++) begin
            bus.op = (k == 0) ? 6'b000011 : 6'b000010;
            tick();
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd11 || bus.pc_wr !== 1'b1 || bus.pc_src !== 2'd2 ||
                bus.rf_wr !== (k == 0) || bus.instr_done !== 1'b1) begin
                errors++;
                $display("FAIL jump_%0d: state=%0d pc_wr=%b src=%0d rf_wr=%b want 11 1 2 %b",
                         k, bus.state, bus.pc_wr, bus.pc_src, bus.rf_wr, (k == 0));
            end
            if (k == 0) begin
                checks++;
                if (bus.rf_a3_sel !== 2'd2 || bus.rf_wd_sel !== 2'd2) begin
                    errors++;
                    $display("FAIL jal_link: a3=%0d wd=%0d want 2 2", bus.rf_a3_sel, bus.rf_wd_sel);
                end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [5:0] opc [2] = '{6'b111111, 6'b000000};
        for (int k = 0; k < 2; k++) begin
            bus.op = opc[k];
            bus.funct = 6'b000000;
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd1 || bus.illegal !== 1'b1 || bus.instr_done !== 1'b0 ||
                bus.pc_wr !== 1'b0 || bus.ir_wr !== 1'b0 || bus.rf_wr !== 1'b0 || bus.dm_wr !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d: state=%0d ill=%b done=%b pc=%b ir=%b rf=%b dm=%b want 1 1 0 0 0 0 0",
                         k, bus.state, bus.illegal, bus.instr_done, bus.pc_wr, bus.ir_wr, bus.rf_wr, bus.dm_wr);
            end
            tick();
            #1;
            checks++;
            if (bus.state !== 4'd0 || bus.illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal_next_%0d: state=%0d ill=%b want 0 0", k, bus.state, bus.illegal);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.op = 6'b000000;
        bus.funct = 6'b000000;
        bus.zero = 1'b0;
        test_reset();
        bus.zero = 1'b0;
        test_addu();
        test_rtype_aluops();
        test_itype();
        test_lw_sw();
        test_beq();
        test_jump();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
